// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse CDC scheduler and its round-robin arbiter.
`timescale 1ns/1ps
package pulse_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} sched_state_e;

  localparam int DEF_MIN_GAP = 15;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_cdc_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search from the pointer upward with wrap, registered pointer.
`timescale 1ns/1ps
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                       i_clk,
  input  logic                       rst,
  input  logic [N-1:0]               i_req_vec,
  input  logic                       i_adv,
  output logic [clog2_min1(N)-1:0]   o_grant_idx,
  output logic                       o_grant_vld
);

  localparam int IDW = clog2_min1(N);

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;
  logic [2*N-1:0] rot_vec;
  logic [IDW:0]   sum;

  // Rotating a doubled vector puts the pointer position at bit 0; scanning
  // from the top down lets the lowest offset win.
  always_comb begin
    rot_vec     = {i_req_vec, i_req_vec} >> ptr_reg;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    sum         = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (rot_vec[off]) begin
        sum = {1'b0, ptr_reg} + (IDW+1)'(off);
        if (sum >= (IDW+1)'(N)) begin
          sum = sum - (IDW+1)'(N);
        end
        o_grant_idx = sum[IDW-1:0];
        o_grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (i_adv && o_grant_vld) begin
      ptr_next = (o_grant_idx == IDW'(N - 1)) ? '0 : o_grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/toggle_sync.sv
// Single-pulse crossing: source-side toggle, three-flop destination synchronizer, edge detect.
`timescale 1ns/1ps
module toggle_sync (
  input  logic i_src_clk,
  input  logic i_dst_clk,
  input  logic rst,
  input  logic i_src_data,
  output logic o_dst_pulse
);

  logic       tog_reg;
  logic [2:0] sync_reg;
  logic       pulse_reg;

  always_ff @(posedge i_src_clk or posedge rst) begin
    if (rst) begin
      tog_reg <= 1'b0;
    end else begin
      tog_reg <= tog_reg ^ i_src_data;
    end
  end

  always_ff @(posedge i_dst_clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= '0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[1:0], tog_reg};
      pulse_reg <= sync_reg[2] ^ sync_reg[1];
    end
  end

  assign o_dst_pulse = pulse_reg;

endmodule

// File: rtl/pulse_cdc_scheduler.sv
// Shares one toggle_sync pulse channel between N requesters: per-requester saturating
// pending counters, round-robin grants, and a forced idle gap after every issued pulse.
`timescale 1ns/1ps
module pulse_cdc_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 4,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input  logic                     i_clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [N_REQ-1:0]         i_req,
  output logic                     o_pulse,
  output logic [$clog2(N_REQ)-1:0] o_pulse_id,
  output logic [N_REQ-1:0]         o_drop,
  output logic                     o_pend_any,
  output logic                     o_busy
);

  localparam int IDW   = clog2_min1(N_REQ);
  localparam int GAP_W = clog2_min1(MIN_GAP);

  sched_state_e   state_reg, state_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic           pulse_reg, pulse_next;
  logic [IDW-1:0] id_reg, id_next;
  logic           pend_reg;

  logic [N_REQ-1:0] nz_vec;
  logic [N_REQ-1:0] nz_next_vec;
  logic [IDW-1:0]   grant_idx;
  logic             grant_vld;
  logic             grant_fire;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             drop_reg, drop_next;
      logic             inc, dec;

      assign inc = i_req[gi];
      assign dec = grant_fire && (grant_idx == IDW'(gi));

      // A request landing in the grant cycle cancels the decrement.
      always_comb begin
        cnt_next  = cnt_reg;
        drop_next = 1'b0;
        if (inc && !dec) begin
          if (cnt_reg == '1) begin
            drop_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else if (dec && !inc && (cnt_reg != '0)) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
          cnt_reg  <= '0;
          drop_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          drop_reg <= drop_next;
        end
      end

      assign nz_vec[gi]      = (cnt_reg != '0);
      assign nz_next_vec[gi] = (cnt_next != '0);
      assign o_drop[gi]      = drop_reg;
    end
  endgenerate

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_clk       (i_clk),
    .rst         (rst),
    .i_req_vec   (nz_vec),
    .i_adv       (grant_fire),
    .o_grant_idx (grant_idx),
    .o_grant_vld (grant_vld)
  );

  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    pulse_next = 1'b0;
    id_next    = '0;
    grant_fire = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_en && grant_vld) begin
          state_next = S_ISSUE;
          grant_fire = 1'b1;
          pulse_next = 1'b1;
          id_next    = grant_idx;
        end
      end
      S_ISSUE: begin
        state_next = S_GAP;
        gap_next   = GAP_W'(MIN_GAP - 1);
      end
      S_GAP: begin
        if (gap_reg == '0) begin
          if (i_en && grant_vld) begin
            state_next = S_ISSUE;
            grant_fire = 1'b1;
            pulse_next = 1'b1;
            id_next    = grant_idx;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      gap_reg   <= '0;
      pulse_reg <= 1'b0;
      id_reg    <= '0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
      pulse_reg <= pulse_next;
      id_reg    <= id_next;
      pend_reg  <= |nz_next_vec;
    end
  end

  assign o_pulse    = pulse_reg;
  assign o_pulse_id = id_reg;
  assign o_pend_any = pend_reg;
  assign o_busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_pulse_cdc_scheduler.sv
// Scoreboard bench for pulse_cdc_scheduler driving a toggle_sync into a 20 ns domain.
`timescale 1ns/1ps
module tb_pulse_cdc_scheduler;

  localparam int N_REQ  = 4;
  localparam int PERIOD = 16;

  logic       clk = 1'b0;
  logic       dst_clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_en = 1'b0;
  logic [3:0] i_req = '0;
  logic       o_pulse;
  logic [1:0] o_pulse_id;
  logic [3:0] o_drop;
  logic       o_pend_any;
  logic       o_busy;
  logic       dst_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int src_pulses = 0;
  int dst_pulses = 0;
  int drop1_cycles = 0;
  int last_pulse = -1;
  logic prev_pulse = 1'b0;
  int exp_q[$];
  int pcyc_q[$];

  always #2 clk = ~clk;
  always #10 dst_clk = ~dst_clk;

  pulse_cdc_scheduler #(.N_REQ(4), .CNT_W(4), .MIN_GAP(15)) dut (
    .i_clk      (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_req      (i_req),
    .o_pulse    (o_pulse),
    .o_pulse_id (o_pulse_id),
    .o_drop     (o_drop),
    .o_pend_any (o_pend_any),
    .o_busy     (o_busy)
  );

  toggle_sync u_sync (
    .i_src_clk   (clk),
    .i_dst_clk   (dst_clk),
    .rst         (rst),
    .i_src_data  (o_pulse),
    .o_dst_pulse (dst_pulse)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_pulse) begin
        src_pulses++;
        pcyc_q.push_back(cyc);
        $display("pulse id=%0d cycle=%0d", o_pulse_id, cyc);
        if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
        else check("pulse_id", int'(o_pulse_id), exp_q.pop_front());
        if (last_pulse >= 0) check("pulse_spacing_min", int'((cyc - last_pulse) >= PERIOD), 1);
        check("pulse_single_cycle", int'(prev_pulse), 0);
        last_pulse = cyc;
      end
      if (o_drop[1]) drop1_cycles++;
      prev_pulse = o_pulse;
    end
  end

  always @(negedge dst_clk) begin
    if (dst_pulse) dst_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = '0;
    i_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    pcyc_q.delete();
    last_pulse = -1;
    prev_pulse = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((o_busy || o_pend_any) && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(o_busy || o_pend_any), 0);
  endtask

  task automatic settle();
    repeat (40) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, n;

    // 1: single request on requester 2
    do_reset();
    check("rst_pulse", int'(o_pulse), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_pend", int'(o_pend_any), 0);
    check("rst_drop", int'(o_drop), 0);
    check("rst_id", int'(o_pulse_id), 0);
    i_en = 1'b1;
    exp_q.push_back(2);
    d0 = dst_pulses;
    i_req = 4'b0100;
    tick();
    i_req = '0;
    check("t1_no_pulse_c1", int'(o_pulse), 0);
    check("t1_pend_c1", int'(o_pend_any), 1);
    tick();
    check("t1_pulse_c2", int'(o_pulse), 1);
    check("t1_id_c2", int'(o_pulse_id), 2);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      tick();
    end
    check("t1_busy_cycles", n, 16);
    settle();
    check("t1_dst_pulses", dst_pulses - d0, 1);
    check("t1_all_seen", exp_q.size(), 0);

    // 2: all requesters at once
    do_reset();
    i_en = 1'b1;
    for (int i = 0; i < N_REQ; i++) exp_q.push_back(i);
    d0 = dst_pulses;
    i_req = 4'hF;
    tick();
    i_req = '0;
    wait_idle("t2_timeout", 200);
    check("t2_pulse_count", pcyc_q.size(), 4);
    if (pcyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++) check("t2_spacing", pcyc_q[i] - pcyc_q[i-1], PERIOD);
    end
    check("t2_pend_end", int'(o_pend_any), 0);
    settle();
    check("t2_dst_pulses", dst_pulses - d0, 4);
    check("t2_all_seen", exp_q.size(), 0);

    // 3: saturation with scheduling disabled
    do_reset();
    drop1_cycles = 0;
    repeat (17) begin
      i_req = 4'b0010;
      tick();
    end
    i_req = '0;
    repeat (3) tick();
    check("t3_drop_cycles", drop1_cycles, 2);
    check("t3_busy_disabled", int'(o_busy), 0);
    check("t3_pend", int'(o_pend_any), 1);
    s0 = src_pulses;
    for (int i = 0; i < 15; i++) exp_q.push_back(1);
    i_en = 1'b1;
    wait_idle("t3_timeout", 15 * PERIOD + 50);
    check("t3_pulse_count", src_pulses - s0, 15);
    check("t3_all_seen", exp_q.size(), 0);

    // 4: request coinciding with a grant to the same requester
    do_reset();
    repeat (3) begin
      i_req = 4'b0001;
      tick();
    end
    i_req = '0;
    tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(0);
    s0 = src_pulses;
    i_en = 1'b1;
    i_req = 4'b0001;
    tick();
    i_req = '0;
    check("t4_pulse_on_en", int'(o_pulse), 1);
    repeat (5) tick();
    i_req = 4'b0001;
    tick();
    i_req = '0;
    wait_idle("t4_timeout", 200);
    check("t4_pulse_count", src_pulses - s0, 5);
    check("t4_all_seen", exp_q.size(), 0);

    // 5: reset in the middle of a gap with queued work
    do_reset();
    i_req = 4'hF;
    tick();
    i_req = 4'b0001;
    tick();
    i_req = '0;
    tick();
    exp_q.push_back(0);
    i_en = 1'b1;
    tick();
    check("t5_issue", int'(o_pulse), 1);
    repeat (5) tick();
    check("t5_busy_in_gap", int'(o_busy), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_pulse", int'(o_pulse), 0);
    check("t5_rst_busy", int'(o_busy), 0);
    check("t5_rst_pend", int'(o_pend_any), 0);
    repeat (2) tick();
    rst = 1'b0;
    last_pulse = -1;
    prev_pulse = 1'b0;
    tick();
    s0 = src_pulses;
    repeat (80) tick();
    check("t5_no_pulse_after_rst", src_pulses - s0, 0);
    for (int i = 0; i < N_REQ; i++) exp_q.push_back(i);
    i_req = 4'hF;
    tick();
    i_req = '0;
    wait_idle("t5_ptr_timeout", 200);
    check("t5_ptr_order_seen", exp_q.size(), 0);

    // 5b: reset while the pulse itself is high
    exp_q.push_back(3);
    i_req = 4'b1000;
    tick();
    i_req = '0;
    tick();
    check("t5b_issue", int'(o_pulse), 1);
    rst = 1'b1;
    #1;
    check("t5b_rst_pulse", int'(o_pulse), 0);
    check("t5b_rst_busy", int'(o_busy), 0);

    // 6: two requesters, ten requests each, through the synchronizer
    do_reset();
    i_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(0);
      exp_q.push_back(2);
    end
    s0 = src_pulses;
    d0 = dst_pulses;
    repeat (10) begin
      i_req = 4'b0101;
      tick();
    end
    i_req = '0;
    wait_idle("t6_timeout", 20 * PERIOD + 100);
    settle();
    check("t6_src_pulses", src_pulses - s0, 20);
    check("t6_dst_pulses", dst_pulses - d0, 20);
    check("t6_dst_eq_src", dst_pulses - d0, src_pulses - s0);
    check("t6_all_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
